axis_byte_serializer: RTL and testbench

//  Upstream neighbour of the AXIS output interface, in the input clock domain.
//  - Accepts LOGIC_SIZE-bit words on an AXI-Stream subordinate port.
//  - Splits each word into bytes, LSB byte first.
//  - Writes one byte per cycle into the async byte FIFO that crosses to the output domain.
//  - A one-word pending register lets the next word be accepted while the current one drains.
//  - Result: sustained 1 byte/cycle, no bubble between words.

---
 rtl/axis_byte_serializer.sv | 110 +++++++++++
 tb/tb_axis_byte_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_serializer.sv
// AXI-Stream word to byte serializer feeding the write side of an async byte FIFO.
// A one-word skid register keeps the byte stream gap-free across word boundaries.
module axis_byte_serializer #(
  parameter int LOGIC_SIZE = 32
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_reset_n,
  input  logic [LOGIC_SIZE-1:0] m_axis_tdata,
  input  logic                  m_axis_valid,
  output logic                  m_axis_ready,
  output logic [7:0]            o_to_fifo,
  input  logic                  w_full,
  output logic                  w_req,
  output logic                  o_busy
);

  localparam int NBYTES = LOGIC_SIZE / 8;
  localparam int CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [LOGIC_SIZE-1:0] sh_data_r;
  logic [LOGIC_SIZE-1:0] pend_data_r;
  logic [CW-1:0]         cnt_r;
  logic                  busy_r;
  logic                  pend_valid_r;
  logic                  ready_r;

  logic [LOGIC_SIZE-1:0] sh_data_s;
  logic [LOGIC_SIZE-1:0] pend_data_s;
  logic [CW-1:0]         cnt_s;
  logic                  busy_s;
  logic                  pend_valid_s;
  logic                  w_req_s;
  logic                  last_s;
  logic                  accept_s;

  assign w_req_s  = busy_r && !w_full;
  assign last_s   = w_req_s && (cnt_r == LAST_IDX);
  assign accept_s = m_axis_valid && ready_r;

  // Next-state for the shift word, byte index and skid register.
  always_comb begin
    sh_data_s    = sh_data_r;
    pend_data_s  = pend_data_r;
    cnt_s        = cnt_r;
    busy_s       = busy_r;
    pend_valid_s = pend_valid_r;

    if (w_req_s) begin
      if (cnt_r != LAST_IDX) begin
        cnt_s = cnt_r + CNT_ONE;
      end else if (pend_valid_r) begin
        sh_data_s    = pend_data_r;
        cnt_s        = CNT_ZERO;
        pend_valid_s = 1'b0;
      end else if (accept_s) begin
        sh_data_s = m_axis_tdata;
        cnt_s     = CNT_ZERO;
      end else begin
        busy_s = 1'b0;
        cnt_s  = CNT_ZERO;
      end
    end else begin
      cnt_s = cnt_r;
    end

    // A word arriving while the last byte drains with an empty skid was loaded above.
    if (accept_s) begin
      if (!busy_r) begin
        sh_data_s = m_axis_tdata;
        cnt_s     = CNT_ZERO;
        busy_s    = 1'b1;
      end else if (last_s && !pend_valid_r) begin
        busy_s = 1'b1;
      end else begin
        pend_data_s  = m_axis_tdata;
        pend_valid_s = 1'b1;
      end
    end else begin
      pend_data_s = pend_data_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
    if (!m_axis_reset_n) begin
      sh_data_r    <= {LOGIC_SIZE{1'b0}};
      pend_data_r  <= {LOGIC_SIZE{1'b0}};
      cnt_r        <= CNT_ZERO;
      busy_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      sh_data_r    <= sh_data_s;
      pend_data_r  <= pend_data_s;
      cnt_r        <= cnt_s;
      busy_r       <= busy_s;
      pend_valid_r <= pend_valid_s;
      ready_r      <= !pend_valid_s;
    end
  end

  assign m_axis_ready = ready_r;
  assign w_req        = w_req_s;
  assign o_to_fifo    = sh_data_r[{cnt_r, 3'b000} +: 8];
  assign o_busy       = busy_r | pend_valid_r;

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Directed bench for axis_byte_serializer with a byte scoreboard on the FIFO write port.
module tb_axis_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic [7:0]  to_fifo;
  logic        w_full = 1'b0;
  logic        w_req;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_byte;

  axis_byte_serializer #(.LOGIC_SIZE(32)) dut (
    .m_axis_aclk   (clk),
    .m_axis_reset_n(rst_n),
    .m_axis_tdata  (tdata),
    .m_axis_valid  (valid),
    .m_axis_ready  (ready),
    .o_to_fifo     (to_fifo),
    .w_full        (w_full),
    .w_req         (w_req),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the word with valid high until the edge where ready is seen high.
  task automatic send_word(input logic [31:0] w);
    int g;
    tdata = w;
    valid = 1'b1;
    g = 0;
    while (!ready && g < 200) begin
      step();
      g++;
    end
    check_eq("send_ready", {31'd0, ready}, 32'd1);
    step();
  endtask

  // Scoreboard: accepted words expand LSB-first, each FIFO write pops one byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (w_req) begin
        check_eq("sb_has_byte", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          sb_byte = exp_q.pop_front();
          check_eq("sb_byte", {24'd0, to_fifo}, {24'd0, sb_byte});
        end
      end
      if (valid && ready) begin
        acc_cnt++;
        for (int i = 0; i < 4; i++) exp_q.push_back(tdata[8*i +: 8]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2_bytes [4];
    logic [7:0] t4_bytes [3];
    logic [7:0] t5_bytes [4];
    logic       saw_ready_low;
    int         acc_base;
    int         g;

    t2_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    t4_bytes = '{8'h22, 8'h33, 8'h44};
    t5_bytes = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};

    // Test 1: reset values and ready rising on the first edge after release.
    #22;
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_wreq", {31'd0, w_req}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_byte", {24'd0, to_fifo}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_low", {31'd0, ready}, 32'd0);
    step();
    check_eq("rel_ready_high", {31'd0, ready}, 32'd1);
    check_eq("rel_wreq", {31'd0, w_req}, 32'd0);
    check_eq("rel_busy", {31'd0, busy}, 32'd0);

    // Test 2: single word, four bytes starting the cycle after accept.
    send_word(32'hDDCCBBAA);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_wreq", {31'd0, w_req}, 32'd1);
      check_eq("t2_byte", {24'd0, to_fifo}, {24'd0, t2_bytes[i]});
      step();
    end
    check_eq("t2_wreq_done", {31'd0, w_req}, 32'd0);
    check_eq("t2_busy_done", {31'd0, busy}, 32'd0);

    // Test 3: back-to-back words with valid held high.
    saw_ready_low = 1'b0;
    send_word(32'h03020100);
    fork
      begin
        send_word(32'h07060504);
        send_word(32'h0B0A0908);
        valid = 1'b0;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          check_eq("t3_wreq", {31'd0, w_req}, 32'd1);
          check_eq("t3_byte", {24'd0, to_fifo}, i);
          if (!ready) saw_ready_low = 1'b1;
          step();
        end
      end
    join
    check_eq("t3_ready_dropped", {31'd0, saw_ready_low}, 32'd1);
    check_eq("t3_wreq_done", {31'd0, w_req}, 32'd0);
    check_eq("t3_busy_done", {31'd0, busy}, 32'd0);

    // Test 4: FIFO full for 5 cycles with the second byte presented.
    send_word(32'h44332211);
    valid = 1'b0;
    check_eq("t4_first", {24'd0, to_fifo}, 32'h11);
    step();
    w_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_full_wreq", {31'd0, w_req}, 32'd0);
      check_eq("t4_full_hold", {24'd0, to_fifo}, 32'h22);
      check_eq("t4_full_busy", {31'd0, busy}, 32'd1);
      step();
    end
    w_full = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_resume_wreq", {31'd0, w_req}, 32'd1);
      check_eq("t4_resume_byte", {24'd0, to_fifo}, {24'd0, t4_bytes[i]});
      step();
    end
    check_eq("t4_wreq_done", {31'd0, w_req}, 32'd0);

    // Test 5: reset after two bytes of a word with another word pending.
    send_word(32'h88776655);
    send_word(32'hCCBBAA99);
    valid = 1'b0;
    step();
    check_eq("t5_busy_pre", {31'd0, busy}, 32'd1);
    check_eq("t5_byte_pre", {24'd0, to_fifo}, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ready", {31'd0, ready}, 32'd0);
    check_eq("t5_rst_wreq", {31'd0, w_req}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_rst_byte", {24'd0, to_fifo}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("t5_rel_ready", {31'd0, ready}, 32'd1);
    send_word(32'h0F0E0D0C);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_wreq", {31'd0, w_req}, 32'd1);
      check_eq("t5_byte", {24'd0, to_fifo}, {24'd0, t5_bytes[i]});
      step();
    end
    check_eq("t5_busy_done", {31'd0, busy}, 32'd0);

    // Test 6: random gaps and back-pressure, checked by the scoreboard.
    acc_base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send_word(32'($urandom));
          valid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 9000; c++) begin
          w_full = ($urandom_range(0, 3) == 0);
          step();
          if (acc_cnt - acc_base >= 1000) break;
        end
        w_full = 1'b0;
      end
    join
    w_full = 1'b0;
    g = 0;
    while (busy && g < 100) begin
      step();
      g++;
    end
    step();
    check_eq("t6_drained", {31'd0, busy}, 32'd0);
    check_eq("t6_accepted", acc_cnt - acc_base, 32'd1000);
    check_eq("t6_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
